// File: rtl/conv_pkg.sv
// Shared pixel/window definitions for the 3x3 convolution datapath.
package conv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WIN_W  = 3 * DATA_W;

    // Column slot index inside a packed window row word (slot * DATA_W = LSB)
    localparam int unsigned COL_L = 2;
    localparam int unsigned COL_M = 1;
    localparam int unsigned COL_R = 0;

    // Shift a packed 3-pixel row left by one column and insert a new rightmost pixel
    function automatic logic [WIN_W-1:0] pushCol(input logic [WIN_W-1:0] row,
                                                 input logic [DATA_W-1:0] pix);
        logic [WIN_W-1:0] res;
        res = '0;
        res[COL_L*DATA_W +: DATA_W] = row[COL_M*DATA_W +: DATA_W];
        res[COL_M*DATA_W +: DATA_W] = row[COL_R*DATA_W +: DATA_W];
        res[COL_R*DATA_W +: DATA_W] = pix;
        return res;
    endfunction

endpackage

// File: rtl/line_delay.sv
// Enabled fixed-depth delay line; dout is the sample written DEPTH enabled beats ago.
module line_delay #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] taps;

    // Shift on each enabled beat; storage is intentionally never cleared
    always_ff @(posedge clk) begin
        if (en) begin
            taps <= {taps[DEPTH-2:0], din};
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/window3x3_linebuf.sv
// Raster-stream line buffer producing packed 3x3 windows for filter3x3.
module window3x3_linebuf
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic [3*DATA_W-1:0] line1,
    output logic [3*DATA_W-1:0] line2,
    output logic [3*DATA_W-1:0] line3,
    output logic                win_valid,
    output logic                frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned ROW3W = 3 * DATA_W;

    logic [COL_W-1:0]  colCnt;
    logic [ROW_W-1:0]  rowCnt;
    logic [DATA_W-1:0] lb0Out;
    logic [DATA_W-1:0] lb1Out;
    logic              lbEn;
    logic              lastCol;
    logic              lastRow;
    logic              inWindow;

    assign lbEn     = in_valid & ~rst;
    assign lastCol  = (colCnt == COL_W'(IMG_W - 1));
    assign lastRow  = (rowCnt == ROW_W'(IMG_H - 1));
    assign inWindow = (colCnt >= COL_W'(2)) && (rowCnt >= ROW_W'(2));

    line_delay #(.DEPTH(IMG_W), .WIDTH(DATA_W)) lb0 (
        .clk  (clk),
        .en   (lbEn),
        .din  (in_data),
        .dout (lb0Out)
    );

    line_delay #(.DEPTH(IMG_W), .WIDTH(DATA_W)) lb1 (
        .clk  (clk),
        .en   (lbEn),
        .din  (lb0Out),
        .dout (lb1Out)
    );

    // Counters, window shift and validity flags, all advanced only on accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            colCnt     <= '0;
            rowCnt     <= '0;
            line1      <= '0;
            line2      <= '0;
            line3      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                line1      <= ROW3W'({line1[2*DATA_W-1:0], lb1Out});
                line2      <= ROW3W'({line2[2*DATA_W-1:0], lb0Out});
                line3      <= ROW3W'({line3[2*DATA_W-1:0], in_data});
                win_valid  <= inWindow;
                frame_done <= lastCol && lastRow;
                if (lastCol) begin
                    colCnt <= '0;
                    rowCnt <= lastRow ? '0 : rowCnt + ROW_W'(1);
                end else begin
                    colCnt <= colCnt + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Self-checking bench for window3x3_linebuf (DATA_W=8, IMG_W=4, IMG_H=4).
module tb_window3x3_linebuf;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;

    typedef struct {
        logic [7:0]  pix;
        logic        expValid;
        logic [23:0] l1;
        logic [23:0] l2;
        logic [23:0] l3;
        logic        fd;
        int          sum;
    } vec_t;

    typedef struct {
        logic [23:0] l1;
        logic [23:0] l2;
        logic [23:0] l3;
        logic        fd;
        int          due;
    } expWin_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [23:0]   line1;
    logic [23:0]   line2;
    logic [23:0]   line3;
    logic          win_valid;
    logic          frame_done;

    int nCmp = 0;
    int nBad = 0;
    int cyc = 0;
    int winSeen = 0;

    expWin_t sbq[$];
    logic [7:0] img[IH][IW];
    int mCol = 0;
    int mRow = 0;
    logic [23:0] prevL1, prevL2, prevL3;

    vec_t tbl[16];

    window3x3_linebuf #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .line1      (line1),
        .line2      (line2),
        .line3      (line3),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rowSum(input logic [23:0] r);
        return int'(r[23:16]) + int'(r[15:8]) + int'(r[7:0]);
    endfunction

    // Reference model: store pixel in frame image, push expected window when complete
    task automatic modelBeat(input logic [7:0] p);
        expWin_t e;
        img[mRow][mCol] = p;
        if (mRow >= 2 && mCol >= 2) begin
            e.l1  = {img[mRow-2][mCol-2], img[mRow-2][mCol-1], img[mRow-2][mCol]};
            e.l2  = {img[mRow-1][mCol-2], img[mRow-1][mCol-1], img[mRow-1][mCol]};
            e.l3  = {img[mRow][mCol-2],   img[mRow][mCol-1],   img[mRow][mCol]};
            e.fd  = (mRow == IH - 1) && (mCol == IW - 1);
            e.due = cyc + 1;
            sbq.push_back(e);
        end
        if (mCol == IW - 1) begin
            mCol = 0;
            mRow = (mRow == IH - 1) ? 0 : mRow + 1;
        end else begin
            mCol++;
        end
    endtask

    task automatic beat(input logic [7:0] p);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = p;
        modelBeat(p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic doRst(input int n, input logic toggle);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst      = 1'b1;
            in_valid = toggle ? 1'(i % 2) : 1'b0;
            in_data  = 8'($urandom);
            sbq.delete();
            mCol = 0;
            mRow = 0;
        end
    endtask

    // Monitor: reset/hold checks and scoreboard comparison one step after each edge
    always @(posedge clk) begin
        expWin_t e;
        #1;
        cyc++;
        if (rst) begin
            chk("rst_outputs", {4'b0, win_valid, frame_done, line1 | line2 | line3}, 32'h0);
        end else begin
            if (!in_valid) begin
                chk("gap_hold", {8'h0, line1 ^ prevL1 ^ 24'h0} | {8'h0, line2 ^ prevL2} | {8'h0, line3 ^ prevL3}, 32'h0);
            end
            if (win_valid) begin
                winSeen++;
                if (sbq.size() == 0) begin
                    chk("unexpected_win", 32'h1, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("win_time", 32'(cyc), 32'(e.due));
                    chk("line1", {8'h0, line1}, {8'h0, e.l1});
                    chk("line2", {8'h0, line2}, {8'h0, e.l2});
                    chk("line3", {8'h0, line3}, {8'h0, e.l3});
                    chk("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
                end
            end else begin
                chk("fd_without_win", {31'h0, frame_done}, 32'h0);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    void'(sbq.pop_front());
                    chk("missing_win", 32'h0, 32'h1);
                end
            end
        end
        prevL1 = line1;
        prevL2 = line2;
        prevL3 = line3;
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{pix: 8'(i), expValid: 1'b0, l1: 24'h0, l2: 24'h0, l3: 24'h0, fd: 1'b0, sum: 0};
        end
        tbl[10] = '{8'd10, 1'b1, 24'h000102, 24'h040506, 24'h08090A, 1'b0, 45};
        tbl[11] = '{8'd11, 1'b1, 24'h010203, 24'h050607, 24'h090A0B, 1'b0, 54};
        tbl[14] = '{8'd14, 1'b1, 24'h040506, 24'h08090A, 24'h0C0D0E, 1'b0, 81};
        tbl[15] = '{8'd15, 1'b1, 24'h050607, 24'h090A0B, 24'h0D0E0F, 1'b1, 90};

        doRst(2, 1'b0);
        @(posedge clk);
        #2;
        chk("reset_state", {6'b0, win_valid, frame_done, line1 | line2 | line3}, 32'h0);

        // Case 1 (+ window sums a unit-coefficient filter3x3 would produce)
        for (int i = 0; i < 16; i++) begin
            beat(tbl[i].pix);
            @(posedge clk);
            #2;
            chk("tbl_valid", {31'h0, win_valid}, {31'h0, tbl[i].expValid});
            chk("tbl_fd", {31'h0, frame_done}, {31'h0, tbl[i].fd});
            if (tbl[i].expValid) begin
                chk("tbl_line1", {8'h0, line1}, {8'h0, tbl[i].l1});
                chk("tbl_line2", {8'h0, line2}, {8'h0, tbl[i].l2});
                chk("tbl_line3", {8'h0, line3}, {8'h0, tbl[i].l3});
                chk("tbl_sum", 32'(rowSum(line1) + rowSum(line2) + rowSum(line3)), 32'(tbl[i].sum));
            end
        end

        // Case 2: same frame with random 1-3 cycle gaps
        for (int i = 0; i < 16; i++) begin
            beat(8'(i));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Case 3: back-to-back frame 16..31
        for (int i = 16; i < 32; i++) beat(8'(i));
        idle(2);

        // Case 4: partial frame, one-cycle reset, then a clean frame
        for (int i = 0; i < 6; i++) beat(8'(100 + i));
        doRst(1, 1'b0);
        for (int i = 0; i < 16; i++) beat(8'(i));
        idle(2);

        // Case 5: reset held with in_valid toggling, then a fresh frame
        doRst(6, 1'b1);
        for (int i = 0; i < 16; i++) beat(8'(40 + i));
        idle(3);

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        chk("win_total", 32'(winSeen), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/window3x3_linebuf.md
Name: window3x3_linebuf

Overview:
Streaming line buffer and 3x3 window generator that sits directly upstream of filter3x3. It accepts a raster-order pixel stream, one pixel per valid beat. It holds the two previous image rows and presents each complete 3x3 neighbourhood as three packed 24-bit row words, matching the filter3x3 inLine1..inLine3 inputs. There is no backpressure; the filter consumes one window per cycle.

Parameters:
DATA_W, 8, pixel width in bits (window word = 3*DATA_W)
IMG_W, 8, pixels per image row (>= 3)
IMG_H, 8, rows per frame (>= 3)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data is a valid pixel this cycle
in_data  in  DATA_W  pixel, raster order (row-major, left to right)
line1  out  3*DATA_W  oldest row of the window
line2  out  3*DATA_W  middle row
line3  out  3*DATA_W  newest row (the row containing the current pixel)
win_valid  out  1  line1..line3 hold a complete, in-image window this cycle
frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. On rst, every output is 0, col/row counters are 0, and all window registers are 0. Line-buffer storage is not cleared; stale data is masked by the row<2 rule below.
- Packing: in each lineN, bits [3*DATA_W-1:2*DATA_W] hold the leftmost (oldest) column and bits [DATA_W-1:0] hold the rightmost (current) column.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on in_valid.
  - col wraps to 0 at IMG_W-1 and increments row.
  - row wraps to 0 at IMG_H-1 together with col; the next frame starts immediately.
- Line buffers: two IMG_W-deep delay lines, advanced only on in_valid.
  - lb0 receives in_data.
  - lb1 receives the output of lb0.
  - lb0_out is therefore the pixel directly above in_data; lb1_out is the pixel two rows above.
- Window shift, on in_valid: each lineN shifts left by DATA_W, and new column entries are loaded as follows:
  - line3 gets in_data.
  - line2 gets lb0_out.
  - line1 gets lb1_out.
- Validity: win_valid is registered high in the cycle after an in_valid beat with col>=2 and row>=2; otherwise it is 0.
  - Latency: 1 cycle from the completing pixel to the window.
  - Windows never span a row boundary. Columns 0 and 1 of each row are suppressed.
  - Each frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
- in_valid low: counters, line buffers and line1..3 hold their values; win_valid is 0 the next cycle. Gaps of any length are transparent.
- frame_done is registered high in the cycle after the beat at row=IMG_H-1, col=IMG_W-1. It coincides with the last win_valid of that frame.
- Reset mid-frame: counters restart at 0. The next pixel is treated as (row 0, col 0), and no window from the interrupted frame is emitted after reset.
- Width rules: counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide. Pixels are passed through unmodified; there is no arithmetic.

Decomposition:
- Shared package conv_pkg:
  - DATA_W default, WIN_W = 3*DATA_W.
  - Column-slot index constants for the packing: COL_L, COL_M, COL_R.
  - This package is shared with filter3x3.
- One sub-module, line_delay: a parameterised DEPTH x WIDTH shift/RAM delay line with an enable. It is instantiated twice, as lb0 and lb1.
- Counters, window registers and valid/frame logic live in the top module.

Test Plan:
All cases use DATA_W=8, IMG_W=4, IMG_H=4.
1. Frame of pixels 0..15, in_valid held high -> the first win_valid comes 1 cycle after beat 10, with line1=0x000102, line2=0x040506, line3=0x08090A. There are 4 windows in total; the last is line1=0x050607, line2=0x090A0B, line3=0x0D0E0F, and frame_done is high in that same cycle.
2. Same frame with in_valid low for 1–3 cycles between random beats -> the same 4 windows in the same order, win_valid never high during a gap, and outputs stable during gaps.
3. Back-to-back second frame with pixels 16..31 -> no win_valid during rows 0–1. The first window is 0x101112 / 0x141516 / 0x18191A, with no leakage from frame 1.
4. rst asserted for 1 cycle after 6 beats, then a full frame 0..15 -> the window sequence and frame_done timing are identical to case 1, with no extra or early windows.
5. rst held high with in_valid toggling -> all outputs stay 0. After release, the first accepted pixel is counted as (0,0).
6. Back-to-back pairing with filter3x3: instantiate the filter with all filter coefficients 1 and feed case-1 windows -> the filter output equals the window sums 45, 54, 81, 90.
